// File: rtl/ex_muldiv_iter.sv
// Execute-stage iterative RV32M divide/remainder unit with pipeline hold and one-cycle write enable.
// Optional EXM_MUL_EN macro adds MUL/MULH/MULHSU/MULHU using a single-cycle product.
module ex_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     exm_instr_in,
  input  logic [4:0]      exm_write_addr_in,
  input  logic [XLEN-1:0] exm_op1_in,
  input  logic [XLEN-1:0] exm_op2_in,
  input  logic            exm_jump_flag_in,
  output logic            exm_hold_flag_out,
  output logic            exm_busy_out,
  output logic [XLEN-1:0] exm_result_out,
  output logic [4:0]      exm_write_addr_out,
  output logic            exm_wen_out
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  counter_q;
  logic [XLEN-1:0]   dividend_q, divisor_q, quotient_q, remainder_q, result_q;
  logic [4:0]        write_addr_q;
  logic [2:0]        funct3_q;
  logic              q_neg_q, r_neg_q;

  logic [2:0]        funct3;
  logic              is_m, decode_ok, start, signed_op;
  logic              op1_neg, op2_neg, div_zero, overflow;
  logic [XLEN-1:0]   op1_abs, op2_abs;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic              step_ge;
  logic [XLEN-1:0]   rem_step, quo_step, quo_signed, rem_signed, div_word;
  logic              mul_op;
  logic [XLEN-1:0]   mul_word;
  logic              instr_unused;

  assign funct3 = exm_instr_in[14:12];
  assign is_m   = (exm_instr_in[6:0] == 7'b0110011) && (exm_instr_in[31:25] == 7'b0000001);
`ifdef EXM_MUL_EN
  assign decode_ok = is_m;
`else
  assign decode_ok = is_m & funct3[2];
`endif

  // Reset and flush both veto a start so the stall request never leaks out of those cycles.
  assign start     = rst & (state == IDLE) & decode_ok & ~exm_jump_flag_in;
  assign signed_op = funct3[2] & ~funct3[0];
  assign op1_neg   = signed_op & exm_op1_in[XLEN-1];
  assign op2_neg   = signed_op & exm_op2_in[XLEN-1];
  assign op1_abs   = op1_neg ? -exm_op1_in : exm_op1_in;
  assign op2_abs   = op2_neg ? -exm_op2_in : exm_op2_in;
  assign div_zero  = (exm_op2_in == '0);
  assign overflow  = signed_op & (exm_op1_in == MIN_NEG) & (exm_op2_in == '1);

  // One restoring step; the extra top bit keeps the trial subtract exact for divisors above 2^(XLEN-1).
  assign rem_shift  = {remainder_q, dividend_q[XLEN-1]};
  assign rem_diff   = rem_shift - {1'b0, divisor_q};
  assign step_ge    = ~rem_diff[XLEN];
  assign rem_step   = step_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_step   = {quotient_q[XLEN-2:0], step_ge};
  assign quo_signed = q_neg_q ? -quo_step : quo_step;
  assign rem_signed = r_neg_q ? -rem_step : rem_step;
  assign div_word   = funct3_q[1] ? rem_signed : quo_signed;

`ifdef EXM_MUL_EN
  logic                   a_signed, b_signed;
  logic signed [XLEN:0]   mul_a, mul_b;
  logic signed [2*XLEN+1:0] prod_full;
  logic                   prod_unused;

  assign a_signed    = (funct3_q[1:0] != 2'b11);
  assign b_signed    = ~funct3_q[1];
  assign mul_a       = {a_signed & dividend_q[XLEN-1], dividend_q};
  assign mul_b       = {b_signed & divisor_q[XLEN-1], divisor_q};
  assign prod_full   = mul_a * mul_b;
  assign mul_op      = ~funct3_q[2];
  assign mul_word    = (funct3_q[1:0] == 2'b00) ? prod_full[XLEN-1:0] : prod_full[2*XLEN-1:XLEN];
  assign prod_unused = ^prod_full[2*XLEN+1:2*XLEN];
`else
  assign mul_op   = 1'b0;
  assign mul_word = '0;
`endif

  assign instr_unused = ^{exm_instr_in[24:15], exm_instr_in[11:7], funct3_q, quotient_q[XLEN-1]};

  // Next-state and handshake outputs; a flush overrides everything and returns to IDLE.
  always_comb begin
    state_next        = state;
    exm_hold_flag_out = 1'b0;
    exm_wen_out       = 1'b0;
    exm_busy_out      = (state != IDLE);
    case (state)
      IDLE: begin
        exm_hold_flag_out = start;
        if (start)
          state_next = (funct3[2] & (div_zero | overflow)) ? DONE : CALC;
      end
      CALC: begin
        exm_hold_flag_out = ~exm_jump_flag_in;
        if (mul_op || counter_q == LAST_STEP)
          state_next = DONE;
      end
      DONE: begin
        exm_wen_out = ~exm_jump_flag_in;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (exm_jump_flag_in)
      state_next = IDLE;
  end

  // The signed result is captured on the edge into DONE so it is already registered during the wen cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      counter_q    <= '0;
      result_q     <= '0;
      write_addr_q <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      funct3_q     <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            funct3_q     <= funct3;
            write_addr_q <= exm_write_addr_in;
            counter_q    <= '0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            if (funct3[2]) begin
              dividend_q <= op1_abs;
              divisor_q  <= op2_abs;
              q_neg_q    <= op1_neg ^ op2_neg;
              r_neg_q    <= op1_neg;
              if (div_zero)
                result_q <= funct3[1] ? exm_op1_in : '1;
              else if (overflow)
                result_q <= funct3[1] ? '0 : MIN_NEG;
            end else begin
              dividend_q <= exm_op1_in;
              divisor_q  <= exm_op2_in;
              q_neg_q    <= 1'b0;
              r_neg_q    <= 1'b0;
            end
          end
        end
        CALC: begin
          if (!exm_jump_flag_in) begin
            if (mul_op) begin
              result_q <= mul_word;
            end else begin
              dividend_q  <= {dividend_q[XLEN-2:0], 1'b0};
              remainder_q <= rem_step;
              quotient_q  <= quo_step;
              counter_q   <= counter_q + CNT_W'(1);
              if (counter_q == LAST_STEP)
                result_q <= div_word;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign exm_result_out     = result_q;
  assign exm_write_addr_out = write_addr_q;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Randomized self-checking bench for ex_muldiv_iter against a cycle-count/arithmetic reference model.
// Build with EXM_MUL_EN defined to also exercise the multiply encodings.
module tb_ex_muldiv_iter;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] exm_instr_in = NOP;
  logic [4:0]  exm_write_addr_in = '0;
  logic [31:0] exm_op1_in = '0;
  logic [31:0] exm_op2_in = '0;
  logic        exm_jump_flag_in = 1'b0;
  logic        exm_hold_flag_out, exm_busy_out, exm_wen_out;
  logic [31:0] exm_result_out;
  logic [4:0]  exm_write_addr_out;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int cyc_left = 0;
  logic [31:0] pend_result = '0;
  logic [4:0]  pend_addr = '0;
  int wen_count = 0;
  int last_wen_cycle = 0;
  logic [31:0] last_result = '0;
  logic [4:0]  last_addr = '0;
  int op_start_cycle = 0;
  int op_hold_cycles = 0;

  ex_muldiv_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .exm_instr_in(exm_instr_in), .exm_write_addr_in(exm_write_addr_in),
    .exm_op1_in(exm_op1_in), .exm_op2_in(exm_op2_in),
    .exm_jump_flag_in(exm_jump_flag_in),
    .exm_hold_flag_out(exm_hold_flag_out), .exm_busy_out(exm_busy_out),
    .exm_result_out(exm_result_out), .exm_write_addr_out(exm_write_addr_out),
    .exm_wen_out(exm_wen_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic bit model_start(input logic [31:0] ins);
    bit m;
    m = (ins[6:0] == 7'b0110011) && (ins[31:25] == 7'b0000001);
`ifdef EXM_MUL_EN
    return m;
`else
    return m && ins[14];
`endif
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint pa, pb;
    logic [63:0] pu;
    bit ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      3'b111: return (b == 0) ? a : a % b;
      3'b000: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'b001: begin pa = sa; pb = sb; pu = pa * pb; return pu[63:32]; end
      3'b010: begin pa = sa; pb = longint'({32'b0, b}); pu = pa * pb; return pu[63:32]; end
      default: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 3;
    if (b == 0) return 2;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Reference: an operation is a countdown of cycles to its wen cycle plus the result it must show.
  always @(negedge clk) begin
    bit s, e_wen;
    cycle++;
    if (!rst) begin
      cyc_left = 0;
      checkOutput("rst_hold", exm_hold_flag_out, 0);
      checkOutput("rst_wen", exm_wen_out, 0);
      checkOutput("rst_busy", exm_busy_out, 0);
    end else begin
      s = (cyc_left == 0) && model_start(exm_instr_in) && !exm_jump_flag_in;
      e_wen = (cyc_left == 1) && !exm_jump_flag_in;
      checkOutput("hold", exm_hold_flag_out, (s || cyc_left > 1) && !exm_jump_flag_in);
      checkOutput("wen", exm_wen_out, e_wen);
      checkOutput("busy", exm_busy_out, cyc_left != 0);
      if (e_wen) begin
        checkOutput("result", exm_result_out, pend_result);
        checkOutput("waddr", exm_write_addr_out, pend_addr);
      end
      if (exm_wen_out) begin
        wen_count++;
        last_wen_cycle = cycle;
        last_result = exm_result_out;
        last_addr = exm_write_addr_out;
      end
      if (exm_jump_flag_in) cyc_left = 0;
      else if (cyc_left > 0) cyc_left--;
      else if (s) begin
        pend_result = ref_result(exm_instr_in[14:12], exm_op1_in, exm_op2_in);
        pend_addr = exm_write_addr_in;
        cyc_left = ref_latency(exm_instr_in[14:12], exm_op1_in, exm_op2_in) - 1;
      end
    end
  end

  // Acts as the decode-to-execute register: the instruction stays until a cycle ends with hold low.
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input int flush_at);
    bit was;
    exm_instr_in = ins;
    exm_op1_in = a;
    exm_op2_in = b;
    exm_write_addr_in = rd;
    op_start_cycle = cycle + 1;
    op_hold_cycles = 0;
    for (int k = 0; k < 100; k++) begin
      exm_jump_flag_in = (k == flush_at);
      @(negedge clk);
      was = exm_hold_flag_out;
      if (was) op_hold_cycles++;
      @(posedge clk);
      #1;
      exm_jump_flag_in = 1'b0;
      if (!was) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL hold_timeout: hold still high after 100 cycles, required low");
  endtask

  task automatic runDirected(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int wc;
    wc = wen_count;
    applyStimulus(mk_instr(f3, 5'd9), a, b, 5'd9, -1);
    checkOutput({name, "_wen_count"}, wen_count - wc, 1);
    checkOutput({name, "_res"}, last_result, exp_res);
    checkOutput({name, "_lat"}, last_wen_cycle - op_start_cycle + 1, exp_lat);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] f3;
    logic [31:0] a, b, ins;
    int flush_at, wc, w1;

    #1 rst = 1'b0;
    #2;
    checkOutput("reset_hold", exm_hold_flag_out, 0);
    checkOutput("reset_wen", exm_wen_out, 0);
    checkOutput("reset_busy", exm_busy_out, 0);
    checkOutput("reset_result", exm_result_out, 0);
    checkOutput("reset_waddr", exm_write_addr_out, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    checkOutput("pin_divu", ref_result(3'b101, 32'd100, 32'd7), 32'd14);
    checkOutput("pin_remu", ref_result(3'b111, 32'd100, 32'd7), 32'd2);
    checkOutput("pin_div_neg", ref_result(3'b100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    checkOutput("pin_rem_neg", ref_result(3'b110, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    checkOutput("pin_mulhu", ref_result(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

    wc = wen_count;
    applyStimulus(mk_instr(3'b101, 5'd5), 32'd100, 32'd7, 5'd5, -1);
    checkOutput("divu_hold_cycles", op_hold_cycles, 33);
    checkOutput("divu_res", last_result, 14);
    checkOutput("divu_addr", last_addr, 5);
    checkOutput("divu_lat", last_wen_cycle - op_start_cycle + 1, 34);
    checkOutput("divu_wen_count", wen_count - wc, 1);
    runDirected("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    runDirected("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    runDirected("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    runDirected("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    runDirected("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 2);
    runDirected("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    runDirected("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);
`ifdef EXM_MUL_EN
    runDirected("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
`endif

    // Asynchronous reset in the middle of a divide.
    exm_instr_in = mk_instr(3'b101, 5'd7);
    exm_op1_in = 32'd100;
    exm_op2_in = 32'd7;
    exm_write_addr_in = 5'd7;
    for (int k = 0; k < 10; k++) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("midreset_busy", exm_busy_out, 0);
    checkOutput("midreset_hold", exm_hold_flag_out, 0);
    checkOutput("midreset_wen", exm_wen_out, 0);
    checkOutput("midreset_result", exm_result_out, 0);
    checkOutput("midreset_waddr", exm_write_addr_out, 0);
    exm_instr_in = NOP;
    @(posedge clk);
    #1 rst = 1'b1;

    // Flush during CALC, then a clean divide.
    wc = wen_count;
    applyStimulus(mk_instr(3'b101, 5'd3), 32'd100, 32'd7, 5'd3, 5);
    checkOutput("flush_no_wen", wen_count - wc, 0);
    checkOutput("flush_hold_cycles", op_hold_cycles, 5);
    runDirected("after_flush", 3'b101, 32'd9, 32'd3, 32'd3, 34);

    // Back-to-back operations followed by idle time.
    wc = wen_count;
    applyStimulus(mk_instr(3'b101, 5'd1), 32'd9, 32'd3, 5'd1, -1);
    w1 = last_wen_cycle;
    checkOutput("b2b_first", last_result, 3);
    applyStimulus(mk_instr(3'b111, 5'd2), 32'd10, 32'd4, 5'd2, -1);
    checkOutput("b2b_second", last_result, 2);
    checkOutput("b2b_spacing", last_wen_cycle - w1, 34);
    for (int k = 0; k < 40; k++) applyStimulus(NOP, 32'd0, 32'd0, 5'd0, -1);
    checkOutput("b2b_wen_total", wen_count - wc, 2);

    // Randomized traffic; the reference process checks every cycle.
    for (int n = 0; n < 60; n++) begin
`ifdef EXM_MUL_EN
      f3 = 3'($urandom_range(0, 7));
`else
      f3 = 3'($urandom_range(4, 7));
`endif
      case ($urandom_range(0, 4))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = 32'd0; end
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin
          a = $urandom_range(0, 200);
          b = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: begin
          a = $urandom;
          b = $urandom_range(1, 16);
          if ($urandom_range(0, 1) == 1) b = -b;
        end
      endcase
      flush_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 36)) : -1;
      applyStimulus(mk_instr(f3, 5'($urandom)), a, b, 5'($urandom), flush_at);
      if ($urandom_range(0, 2) == 0) begin
        ins = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          ins[6:0] = 7'b0110011;
          ins[31:25] = 7'b0000000;
        end else begin
          ins[6:0] = 7'b0110011;
          ins[31:25] = 7'b0000001;
          ins[14] = 1'b0;
        end
        applyStimulus(ins, $urandom, $urandom, 5'($urandom), -1);
      end
    end
    for (int k = 0; k < 5; k++) applyStimulus(NOP, 32'd0, 32'd0, 5'd0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
